// File: rtl/heatmap_pixel_writer_pkg.sv
// Shared constants, state encoding and pixel addressing helper for the heatmap pixel writer.
package heatmap_pkg;

    localparam int H_RES     = 320;
    localparam int V_RES     = 240;
    localparam int ROW_SHIFT = 10;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    localparam logic [8:0] X_LIM  = 9'(H_RES);
    localparam logic [8:0] X_LAST = 9'(H_RES - 1);
    localparam logic [7:0] Y_LIM  = 8'(V_RES);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Rows are padded to 1024 bytes so the row offset is a pure shift.
    function automatic logic [31:0] pix_offset(input logic [8:0] x, input logic [7:0] y);
        return ({24'd0, y} << ROW_SHIFT) + ({23'd0, x} << 1);
    endfunction

endpackage

// File: rtl/heatmap_pixel_writer_if.sv
// Avalon-MM write-only master bus used by the heatmap pixel writer.
interface heatmap_pixel_writer_if;
    logic [31:0] m_address;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [1:0]  m_byteenable;
    logic        m_waitrequest;

    modport master (
        output m_address, m_write, m_writedata, m_byteenable,
        input  m_waitrequest
    );

    modport slave (
        input  m_address, m_write, m_writedata, m_byteenable,
        output m_waitrequest
    );
endinterface

// File: rtl/heatmap_pixel_writer_color_ramp.sv
// Maps an 8-bit heat intensity onto a blue->green->red RGB565 ramp.
module heatmap_color_ramp
    import heatmap_pkg::*;
(
    input  logic [7:0]  value,
    output logic [15:0] rgb
);

    logic [R_W-1:0] r_s;
    logic [G_W-1:0] g_s;
    logic [B_W-1:0] b_s;
    logic           unused_s;

    // Lower half fades blue into green, upper half fades green into red.
    always_comb begin
        r_s = 5'd0;
        g_s = 6'd0;
        b_s = 5'd0;
        if (value[7] == 1'b0) begin
            r_s = 5'd0;
            g_s = value[6:1];
            b_s = 5'd31 - value[6:2];
        end else begin
            r_s = value[6:2];
            g_s = 6'd63 - value[6:1];
            b_s = 5'd0;
        end
    end

    assign rgb      = {r_s, g_s, b_s};
    assign unused_s = value[0];

endmodule

// File: rtl/heatmap_pixel_writer.sv
// Writes single heat pixels or sweeps a full 320x240 RGB565 clear over an Avalon-MM master.
module heatmap_pixel_writer
    import heatmap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [8:0]                    cmd_x,
    input  logic [7:0]                    cmd_y,
    input  logic [7:0]                    cmd_value,
    input  logic                          clear_req,
    heatmap_pixel_writer_if.master        avm,
    output logic                          busy,
    output logic                          clear_done,
    output logic                          drop_err
);

    state_e      state_r, state_s;
    logic        m_write_r, m_write_s;
    logic [31:0] m_address_r, m_address_s;
    logic [15:0] m_writedata_r, m_writedata_s;
    logic        clear_done_r, clear_done_s;
    logic        drop_err_r, drop_err_s;
    logic [8:0]  sweep_x_r, sweep_x_s;
    logic [7:0]  sweep_y_r, sweep_y_s;
    logic [15:0] ramp_rgb_s;
    logic        beat_s;

    heatmap_color_ramp u_ramp (
        .value (cmd_value),
        .rgb   (ramp_rgb_s)
    );

    assign beat_s = m_write_r && !avm.m_waitrequest;

    // Next-state and next-output logic; all bus outputs come straight from registers.
    always_comb begin
        state_s       = state_r;
        m_write_s     = m_write_r;
        m_address_s   = m_address_r;
        m_writedata_s = m_writedata_r;
        clear_done_s  = 1'b0;
        drop_err_s    = drop_err_r;
        sweep_x_s     = sweep_x_r;
        sweep_y_s     = sweep_y_r;
        case (state_r)
            ST_IDLE: begin
                m_write_s = 1'b0;
                if (clear_req) begin
                    state_s       = ST_CLEAR;
                    drop_err_s    = 1'b0;
                    sweep_x_s     = 9'd0;
                    sweep_y_s     = 8'd0;
                    m_write_s     = 1'b1;
                    m_address_s   = BASE_ADDR;
                    m_writedata_s = CLEAR_COLOR;
                end else if (cmd_valid) begin
                    if ((cmd_x < X_LIM) && (cmd_y < Y_LIM)) begin
                        state_s       = ST_WRITE;
                        m_write_s     = 1'b1;
                        m_address_s   = BASE_ADDR + pix_offset(cmd_x, cmd_y);
                        m_writedata_s = ramp_rgb_s;
                    end else begin
                        drop_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (beat_s) begin
                    state_s   = ST_IDLE;
                    m_write_s = 1'b0;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_CLEAR: begin
                if (beat_s) begin
                    if ((sweep_x_r == X_LAST) && (sweep_y_r == Y_LAST)) begin
                        state_s      = ST_IDLE;
                        m_write_s    = 1'b0;
                        clear_done_s = 1'b1;
                    end else begin
                        if (sweep_x_r == X_LAST) begin
                            sweep_x_s = 9'd0;
                            sweep_y_s = sweep_y_r + 8'd1;
                        end else begin
                            sweep_x_s = sweep_x_r + 9'd1;
                        end
                        m_address_s = BASE_ADDR + pix_offset(sweep_x_s, sweep_y_s);
                    end
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                m_write_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset abandoning any transfer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            m_write_r     <= 1'b0;
            m_address_r   <= BASE_ADDR;
            m_writedata_r <= 16'h0000;
            clear_done_r  <= 1'b0;
            drop_err_r    <= 1'b0;
            sweep_x_r     <= 9'd0;
            sweep_y_r     <= 8'd0;
        end else begin
            state_r       <= state_s;
            m_write_r     <= m_write_s;
            m_address_r   <= m_address_s;
            m_writedata_r <= m_writedata_s;
            clear_done_r  <= clear_done_s;
            drop_err_r    <= drop_err_s;
            sweep_x_r     <= sweep_x_s;
            sweep_y_r     <= sweep_y_s;
        end
    end

    assign cmd_ready        = (state_r == ST_IDLE) && !clear_req && !reset;
    assign busy             = (state_r != ST_IDLE);
    assign clear_done       = clear_done_r;
    assign drop_err         = drop_err_r;
    assign avm.m_write      = m_write_r;
    assign avm.m_address    = m_address_r;
    assign avm.m_writedata  = m_writedata_r;
    assign avm.m_byteenable = 2'b11;

endmodule

// File: tb/tb_heatmap_pixel_writer.sv
// Directed bench for heatmap_pixel_writer: vector table plus hand-written wait, clear and reset sequences.
module tb_heatmap_pixel_writer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_value;
    logic        clear_req;
    logic        busy;
    logic        clear_done;
    logic        drop_err;

    heatmap_pixel_writer_if bus ();

    heatmap_pixel_writer #(.BASE_ADDR(BASE), .CLEAR_COLOR(16'h0000)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_value  (cmd_value),
        .clear_req  (clear_req),
        .avm        (bus),
        .busy       (busy),
        .clear_done (clear_done),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [7:0]  v;
        logic        wr;
        logic [31:0] off;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        seen_drop;
        logic [31:0] hold_addr;
        int          n;
        int          seq_err;
        logic [31:0] last_addr;

        vecs[0] = '{x: 9'd0,   y: 8'd0,   v: 8'd0,   wr: 1'b1, off: 32'h0000_0000, data: 16'h001F};
        vecs[1] = '{x: 9'd5,   y: 8'd3,   v: 8'd127, wr: 1'b1, off: 32'h0000_0C0A, data: 16'h07E0};
        vecs[2] = '{x: 9'd6,   y: 8'd3,   v: 8'd128, wr: 1'b1, off: 32'h0000_0C0C, data: 16'h07E0};
        vecs[3] = '{x: 9'd100, y: 8'd200, v: 8'd255, wr: 1'b1, off: 32'h0003_20C8, data: 16'hF800};
        vecs[4] = '{x: 9'd10,  y: 8'd1,   v: 8'd64,  wr: 1'b1, off: 32'h0000_0414, data: 16'h040F};
        vecs[5] = '{x: 9'd2,   y: 8'd2,   v: 8'd200, wr: 1'b1, off: 32'h0000_0804, data: 16'h9360};
        vecs[6] = '{x: 9'd320, y: 8'd5,   v: 8'd9,   wr: 1'b0, off: 32'h0000_0000, data: 16'h0000};
        vecs[7] = '{x: 9'd0,   y: 8'd240, v: 8'd1,   wr: 1'b0, off: 32'h0000_0000, data: 16'h0000};

        reset = 1'b1; cmd_valid = 1'b0; cmd_x = 9'd0; cmd_y = 8'd0; cmd_value = 8'd0;
        clear_req = 1'b0; bus.m_waitrequest = 1'b0;
        step();
        step();
        chk("rst_m_write", {31'd0, bus.m_write}, 32'd0);
        chk("rst_addr", bus.m_address, BASE);
        chk("rst_data", {16'd0, bus.m_writedata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
        chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Table of single commands with no wait states
        seen_drop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_x = vecs[i].x; cmd_y = vecs[i].y; cmd_value = vecs[i].v;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
            step();
            cmd_valid = 1'b0;
            if (!vecs[i].wr) seen_drop = 1'b1;
            chk($sformatf("v%0d_m_write", i), {31'd0, bus.m_write}, {31'd0, vecs[i].wr});
            chk($sformatf("v%0d_drop_err", i), {31'd0, drop_err}, {31'd0, seen_drop});
            chk($sformatf("v%0d_byteen", i), {30'd0, bus.m_byteenable}, 32'd3);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_addr", i), bus.m_address, BASE + vecs[i].off);
                chk($sformatf("v%0d_data", i), {16'd0, bus.m_writedata}, {16'd0, vecs[i].data});
                chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            end else begin
                chk($sformatf("v%0d_ready_after", i), {31'd0, cmd_ready}, 32'd1);
            end
            step();
            chk($sformatf("v%0d_m_write_off", i), {31'd0, bus.m_write}, 32'd0);
            chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
        end

        // Corner pixel with three wait cycles; clear_req pulsed mid-write must be ignored
        cmd_valid = 1'b1; cmd_x = 9'd319; cmd_y = 8'd239; cmd_value = 8'd255;
        bus.m_waitrequest = 1'b1;
        step();
        cmd_valid = 1'b0;
        hold_addr = bus.m_address;
        chk("ws_addr", hold_addr, BASE + 32'h0003_BE7E);
        for (int i = 0; i < 4; i++) begin
            bus.m_waitrequest = (i < 3);
            clear_req = (i == 1);
            #1;
            chk($sformatf("ws%0d_m_write", i), {31'd0, bus.m_write}, 32'd1);
            chk($sformatf("ws%0d_addr", i), bus.m_address, BASE + 32'h0003_BE7E);
            chk($sformatf("ws%0d_data", i), {16'd0, bus.m_writedata}, 32'h0000_F800);
            chk($sformatf("ws%0d_ready", i), {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        clear_req = 1'b0;
        bus.m_waitrequest = 1'b0;
        chk("ws_m_write_off", {31'd0, bus.m_write}, 32'd0);
        chk("ws_busy_off", {31'd0, busy}, 32'd0);
        step();
        chk("ws_clear_ignored", {31'd0, busy}, 32'd0);
        chk("ws_drop_still", {31'd0, drop_err}, 32'd1);

        // Full clear sweep with a competing command
        clear_req = 1'b1; cmd_valid = 1'b1; cmd_x = 9'd1; cmd_y = 8'd1; cmd_value = 8'd1;
        #1;
        chk("clr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        clear_req = 1'b0; cmd_valid = 1'b0;
        chk("clr_drop_cleared", {31'd0, drop_err}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        n = 0; seq_err = 0; last_addr = 32'd0;
        while (bus.m_write && n < 80000) begin
            if (bus.m_address !== BASE + {14'd0, 8'(n / 320), 10'd0} + {22'd0, 9'(n % 320), 1'b0})
                seq_err++;
            if (bus.m_writedata !== 16'h0000 || clear_done !== 1'b0)
                seq_err++;
            last_addr = bus.m_address;
            n++;
            step();
        end
        chk("clr_count", n, 32'd76800);
        chk("clr_seq_err", seq_err, 32'd0);
        chk("clr_last_addr", last_addr, BASE + 32'h0003_BE7E);
        chk("clr_done_pulse", {31'd0, clear_done}, 32'd1);
        chk("clr_idle", {31'd0, busy}, 32'd0);
        step();
        chk("clr_done_one", {31'd0, clear_done}, 32'd0);

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("mid_m_write", {31'd0, bus.m_write}, 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_m_write", {31'd0, bus.m_write}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", bus.m_address, BASE);
        reset = 1'b0;
        step();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_no_resume", {31'd0, bus.m_write}, 32'd0);
        cmd_valid = 1'b1; cmd_x = 9'd2; cmd_y = 8'd2; cmd_value = 8'd200;
        #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("post_rst_m_write", {31'd0, bus.m_write}, 32'd1);
        chk("post_rst_addr", bus.m_address, BASE + 32'h0000_0804);
        chk("post_rst_data", {16'd0, bus.m_writedata}, 32'h0000_9360);
        step();
        chk("post_rst_m_write_off", {31'd0, bus.m_write}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heatmap_pixel_writer.md
HEATMAP_PIXEL_WRITER -- requirements
Module: heatmap_pixel_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the pixel buffer as seen from the FPGA-side Avalon-MM master.
REQ-003 Parameter CLEAR_COLOR, default 16'h0000: RGB565 value written during a clear sweep.
REQ-004 Ports:
- CLOCK_50  in  1  clock.
- reset  in  1  sync active-high reset.
- cmd_valid  in  1  pixel command valid.
- cmd_ready  out  1  pixel command accepted when high with cmd_valid.
- cmd_x  in  9  pixel column.
- cmd_y  in  8  pixel row.
- cmd_value  in  8  heat intensity.
- clear_req  in  1  one-cycle request to clear the frame.
- m_address  out  32  Avalon-MM byte address.
- m_write  out  1  Avalon-MM write.
- m_writedata  out  16  RGB565 pixel.
- m_byteenable  out  2  constant 2'b11.
- m_waitrequest  in  1  Avalon-MM wait.
- busy  out  1  high in any state other than IDLE.
- clear_done  out  1  one-cycle pulse at the end of a clear sweep.
- drop_err  out  1  sticky flag: an out-of-range command was dropped.

Function
REQ-005 The frame SHALL be 320x240 and 16 bpp; address = BASE_ADDR + (y<<10) + (x<<1).
REQ-006 The FSM SHALL have the states IDLE, WRITE and CLEAR; the reset state SHALL be IDLE.
REQ-007 cmd_ready SHALL equal (state==IDLE) && !clear_req && !reset.
REQ-008 A command accepted in cycle N with x<320 and y<240 SHALL register its address and color and drive m_write=1 in cycle N+1; the state SHALL go to WRITE.
REQ-009 A command accepted with x>=320 or y>=240 SHALL cause no write, SHALL set drop_err, and the state SHALL stay IDLE.
REQ-010 In WRITE, m_address, m_writedata and m_write SHALL hold stable while m_waitrequest=1.
REQ-011 In WRITE, a beat (m_write && !m_waitrequest) SHALL return the state to IDLE on the next cycle, which deasserts m_write; peak rate is one pixel per 2 cycles.
REQ-012 The color SHALL be RGB565 {R5,G6,B5}:
- v<128: R=0, G=v[6:1], B=31-v[6:2].
- v>=128: R=v[6:2], G=63-v[6:1], B=0.
REQ-013 clear_req in IDLE SHALL do all of the following:
- go to CLEAR;
- clear drop_err;
- reset the sweep counters to (0,0);
- drive m_write=1 with CLEAR_COLOR from the next cycle.
REQ-014 In CLEAR, each beat SHALL advance x; when x wraps at 319 to 0, y SHALL increment. Writes SHALL be issued back-to-back with no idle cycle.
REQ-015 The beat at (319,239) SHALL end the sweep: the next cycle SHALL be IDLE with m_write=0 and clear_done=1 for exactly one cycle; total writes = 76800.
REQ-016 clear_req while busy SHALL be ignored.
REQ-017 clear_req and cmd_valid together in IDLE: clear SHALL win and the command SHALL NOT be accepted.

Reset
REQ-018 While reset is high, the block SHALL force, at each edge:
- state=IDLE;
- m_write=0, m_address=BASE_ADDR, m_writedata=0;
- busy=0, clear_done=0, drop_err=0;
- sweep counters=0.
REQ-019 A reset asserted mid-WRITE or mid-CLEAR SHALL abandon the transfer with no resumption, and m_write SHALL be 0 from the first reset edge.

Structure
REQ-020 Package heatmap_pkg SHALL hold:
- H_RES=320, V_RES=240, ROW_SHIFT=10;
- the state enum;
- the RGB565 field widths.
REQ-021 The color ramp SHALL be one combinational sub-module, heatmap_color_ramp (8-bit in, 16-bit out).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Cmd (x=0,y=0,v=0), no wait -> one write: addr=BASE, data=16'h001F, m_write high exactly 1 cycle, starting 1 cycle after accept.
- Cmd (319,239,255) with waitrequest high 3 cycles -> addr=BASE+0x3BE7E, data=16'hF800, m_write held 4 cycles with stable signals, cmd_ready low throughout.
- Cmds v=127 and v=128 -> both data=16'h07E0.
- Cmd (320,5,9) -> no m_write, drop_err=1, cmd_ready high next cycle; a later clear_req -> drop_err=0.
- clear_req with cmd_valid also high, no wait -> cmd not accepted; 76800 consecutive writes of 16'h0000, last addr=BASE+0x3BE7E, then clear_done pulse 1 cycle.
- reset after 100 clear writes -> m_write=0, busy=0 next cycle; a following cmd is accepted normally.
